// File: rtl/cgra0_conf_ctrl_pkg.sv
// rtl/cgra0_conf_ctrl_pkg.sv - shared widths and state encoding for the CGRA configuration controller
package cgra0_conf_ctrl_pkg;

  localparam int CONF_WIDTH_DEF   = 64;
  localparam int LEN_WIDTH_DEF    = 16;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int RUN_WIDTH        = 32;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_LOAD   = 3'd1;
  localparam logic [2:0] ENC_DRAIN  = 3'd2;
  localparam logic [2:0] ENC_RUN    = 3'd3;
  localparam logic [2:0] ENC_FINISH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_LOAD   = ENC_LOAD,
    ST_DRAIN  = ENC_DRAIN,
    ST_RUN    = ENC_RUN,
    ST_FINISH = ENC_FINISH
  } state_e;

endpackage

// File: rtl/cgra0_conf_ctrl_reg_pipe.sv
// rtl/cgra0_conf_ctrl_reg_pipe.sv - single-stage register with async active-high clear
module cgra0_conf_ctrl_reg_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/cgra0_conf_ctrl.sv
// rtl/cgra0_conf_ctrl.sv - loads a configuration stream into the PE array, drains, then runs it
module cgra0_conf_ctrl
  import cgra0_conf_ctrl_pkg::*;
#(
  parameter int CONF_WIDTH   = CONF_WIDTH_DEF,
  parameter int LEN_WIDTH    = LEN_WIDTH_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  conf_len,
  input  logic [RUN_WIDTH-1:0]  run_cycles,
  input  logic                  conf_valid,
  input  logic [CONF_WIDTH-1:0] conf_data,
  output logic                  conf_ready,
  output logic [CONF_WIDTH-1:0] conf_bus_out,
  input  logic                  stall,
  input  logic                  pe_done,
  output logic                  en_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  conf_len_q;
  logic [LEN_WIDTH-1:0]  word_cnt_q;
  logic [RUN_WIDTH-1:0]  run_cycles_q;
  logic [RUN_WIDTH-1:0]  run_cnt_q;
  logic [7:0]            drain_cnt_q;
  logic [CONF_WIDTH-1:0] bus_d;
  logic                  accept;
  logic                  run_hit;

  assign conf_ready = (state_q == ST_LOAD);
  assign accept     = conf_ready & conf_valid;
  assign en_out     = (state_q == ST_RUN) & ~stall;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);

  // Bus carries a word only in the cycle after it was accepted; zero otherwise.
  assign bus_d   = accept ? conf_data : '0;
  assign run_hit = (run_cycles_q != '0) && en_out && ((run_cnt_q + 32'd1) == run_cycles_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      conf_len_q   <= '0;
      word_cnt_q   <= '0;
      run_cycles_q <= '0;
      run_cnt_q    <= '0;
      drain_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            conf_len_q   <= conf_len;
            run_cycles_q <= run_cycles;
            word_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            run_cnt_q    <= '0;
            state_q      <= (conf_len != '0) ? ST_LOAD : ST_DRAIN;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
            if ((word_cnt_q + LEN_WIDTH'(1)) == conf_len_q) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) state_q <= ST_RUN;
          else                           drain_cnt_q <= drain_cnt_q + 8'd1;
        end
        ST_RUN: begin
          // Saturate so an open-ended run never wraps back to zero.
          if (en_out && (run_cnt_q != '1)) run_cnt_q <= run_cnt_q + 32'd1;
          if (pe_done || run_hit) state_q <= ST_FINISH;
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  cgra0_conf_ctrl_reg_pipe #(
    .WIDTH (CONF_WIDTH)
  ) u_bus_pipe (
    .clk    (clk),
    .rst    (rst),
    .data_i (bus_d),
    .data_o (conf_bus_out)
  );

endmodule

// File: tb/tb_cgra0_conf_ctrl.sv
// tb/tb_cgra0_conf_ctrl.sv - directed self-checking bench for cgra0_conf_ctrl
module tb_cgra0_conf_ctrl;

  localparam int CW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] conf_len = '0;
  logic [31:0]   run_cycles = '0;
  logic          conf_valid = 1'b0;
  logic [CW-1:0] conf_data = '0;
  logic          conf_ready;
  logic [CW-1:0] conf_bus_out;
  logic          stall = 1'b0;
  logic          pe_done = 1'b0;
  logic          en_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] words [0:2];
  bit            vpat [0:63];
  bit            spat [0:63];
  int            pe_cyc;
  int            start2_cyc;
  int            wi;
  logic [CW-1:0] bus_log [0:63];
  bit            en_log [0:63];
  bit            done_log [0:63];
  bit            ready_log [0:63];
  bit            busy_log [0:63];

  cgra0_conf_ctrl #(
    .CONF_WIDTH   (CW),
    .LEN_WIDTH    (LW),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .conf_len     (conf_len),
    .run_cycles   (run_cycles),
    .conf_valid   (conf_valid),
    .conf_data    (conf_data),
    .conf_ready   (conf_ready),
    .conf_bus_out (conf_bus_out),
    .stall        (stall),
    .pe_done      (pe_done),
    .en_out       (en_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic defaults();
    for (int i = 0; i < 64; i++) begin
      vpat[i] = 1'b1;
      spat[i] = 1'b0;
    end
    pe_cyc = -1;
    start2_cyc = -1;
  endtask

  // Cycle 0 asserts start; every later cycle drives the pattern tables and logs outputs.
  task automatic go(input int len, input int rc, input int n);
    wi = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (c == start2_cyc);
      conf_len   = (c == start2_cyc) ? 16'd3 : 16'(len);
      run_cycles = 32'(rc);
      conf_valid = vpat[c];
      conf_data  = (wi < 3) ? words[wi] : '0;
      stall      = spat[c];
      pe_done    = (c == pe_cyc);
      #1;
      bus_log[c]   = conf_bus_out;
      en_log[c]    = en_out;
      done_log[c]  = done;
      ready_log[c] = conf_ready;
      busy_log[c]  = busy;
      if (conf_valid && conf_ready) wi++;
    end
    start = 1'b0; conf_valid = 1'b0; stall = 1'b0; pe_done = 1'b0;
  endtask

  function automatic int first_en(input int n);
    for (int i = 0; i < n; i++) if (en_log[i]) return i;
    return -1;
  endfunction

  function automatic int count_en(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (en_log[i]) k++;
    return k;
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (done_log[i]) k++;
    return k;
  endfunction

  function automatic int done_at(input int n);
    for (int i = 0; i < n; i++) if (done_log[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({conf_ready, en_out, busy, done} !== 4'b0000 || conf_bus_out !== '0) begin
      failures++;
      $display("FAIL reset_hold got ready=%b en=%b busy=%b done=%b bus=%h exp all 0",
               conf_ready, en_out, busy, done, conf_bus_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({conf_ready, en_out, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle got ready=%b en=%b busy=%b done=%b exp 0000", conf_ready, en_out, busy, done);
    end
  endtask

  task automatic test_basic();
    defaults();
    go(3, 10, 22);
    checks++;
    if (ready_log[1] !== 1'b1 || ready_log[4] !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready got c1=%b c4=%b exp 1 0", ready_log[1], ready_log[4]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_log[2+i] !== words[i]) begin
        failures++;
        $display("FAIL basic_bus_word%0d got %h exp %h", i, bus_log[2+i], words[i]);
      end
    end
    for (int c = 5; c <= 8; c++) begin
      checks++;
      if (bus_log[c] !== '0) begin
        failures++;
        $display("FAIL basic_bus_drain c%0d got %h exp 0", c, bus_log[c]);
      end
    end
    checks++;
    if (first_en(22) !== 8) begin
      failures++;
      $display("FAIL basic_latency got %0d exp 8", first_en(22));
    end
    checks++;
    if (count_en(22) !== 10) begin
      failures++;
      $display("FAIL basic_en_count got %0d exp 10", count_en(22));
    end
    checks++;
    if (count_done(22) !== 1 || done_at(22) !== 18) begin
      failures++;
      $display("FAIL basic_done got count=%0d at=%0d exp 1 at 18", count_done(22), done_at(22));
    end
    checks++;
    if (busy_log[19] !== 1'b0 || en_log[18] !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got busy19=%b en18=%b exp 0 0", busy_log[19], en_log[18]);
    end
  endtask

  task automatic test_valid_gaps();
    logic [CW-1:0] exp_bus [0:4];
    defaults();
    for (int i = 0; i < 64; i++) vpat[i] = 1'b0;
    vpat[1] = 1'b1; vpat[3] = 1'b1; vpat[5] = 1'b1;
    exp_bus[0] = words[0]; exp_bus[1] = '0; exp_bus[2] = words[1]; exp_bus[3] = '0; exp_bus[4] = words[2];
    go(3, 2, 16);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_log[2+i] !== exp_bus[i]) begin
        failures++;
        $display("FAIL gaps_bus c%0d got %h exp %h", 2 + i, bus_log[2+i], exp_bus[i]);
      end
    end
    checks++;
    if (wi !== 3 || ready_log[5] !== 1'b1 || ready_log[6] !== 1'b0) begin
      failures++;
      $display("FAIL gaps_accept got words=%0d r5=%b r6=%b exp 3 1 0", wi, ready_log[5], ready_log[6]);
    end
    checks++;
    if (first_en(16) !== 10 || done_at(16) !== 12) begin
      failures++;
      $display("FAIL gaps_timing got en=%0d done=%0d exp 10 12", first_en(16), done_at(16));
    end
  endtask

  task automatic test_stall();
    defaults();
    spat[8] = 1'b1; spat[9] = 1'b1; spat[10] = 1'b1;
    go(1, 5, 18);
    checks++;
    if (count_en(18) !== 5 || en_log[9] !== 1'b0) begin
      failures++;
      $display("FAIL stall_en got count=%0d en9=%b exp 5 0", count_en(18), en_log[9]);
    end
    checks++;
    if (done_at(18) !== 14 || count_done(18) !== 1) begin
      failures++;
      $display("FAIL stall_finish got at=%0d count=%0d exp 14 1", done_at(18), count_done(18));
    end
  endtask

  task automatic test_pe_done();
    int late_en;
    defaults();
    pe_cyc = 26;
    go(1, 0, 32);
    late_en = 0;
    for (int c = 27; c < 32; c++) if (en_log[c]) late_en++;
    checks++;
    if (done_at(32) !== 27 || count_done(32) !== 1) begin
      failures++;
      $display("FAIL pedone_done got at=%0d count=%0d exp 27 1", done_at(32), count_done(32));
    end
    checks++;
    if (count_en(32) !== 21 || late_en !== 0) begin
      failures++;
      $display("FAIL pedone_en got count=%0d late=%0d exp 21 0", count_en(32), late_en);
    end
  endtask

  task automatic test_reset_mid_load();
    defaults();
    go(3, 10, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({conf_ready, en_out, busy, done} !== 4'b0000 || conf_bus_out !== '0) begin
      failures++;
      $display("FAIL midload_reset got ready=%b en=%b busy=%b done=%b bus=%h exp all 0",
               conf_ready, en_out, busy, done, conf_bus_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    go(3, 2, 16);
    checks++;
    if (bus_log[2] !== words[0] || bus_log[3] !== words[1] || bus_log[4] !== words[2]) begin
      failures++;
      $display("FAIL midload_reload got %h %h %h exp %h %h %h",
               bus_log[2], bus_log[3], bus_log[4], words[0], words[1], words[2]);
    end
    checks++;
    if (first_en(16) !== 8 || count_done(16) !== 1) begin
      failures++;
      $display("FAIL midload_run got en=%0d done=%0d exp 8 1", first_en(16), count_done(16));
    end
  endtask

  task automatic test_zero_len();
    int rdy;
    defaults();
    start2_cyc = 8;
    pe_cyc = 12;
    go(0, 0, 16);
    rdy = 0;
    for (int c = 0; c < 16; c++) if (ready_log[c]) rdy++;
    checks++;
    if (rdy !== 0) begin
      failures++;
      $display("FAIL zlen_ready got %0d ready cycles exp 0", rdy);
    end
    checks++;
    if (first_en(16) !== 5 || busy_log[1] !== 1'b1) begin
      failures++;
      $display("FAIL zlen_latency got en=%0d busy1=%b exp 5 1", first_en(16), busy_log[1]);
    end
    checks++;
    if (done_at(16) !== 13 || count_done(16) !== 1 || busy_log[14] !== 1'b0 || busy_log[15] !== 1'b0) begin
      failures++;
      $display("FAIL zlen_ignore_start got done=%0d count=%0d busy14=%b busy15=%b exp 13 1 0 0",
               done_at(16), count_done(16), busy_log[14], busy_log[15]);
    end
  endtask

  initial begin
    words[0] = 64'hA0A0_0000_1111_0001;
    words[1] = 64'hB0B0_0000_2222_0002;
    words[2] = 64'hC0C0_0000_3333_0003;
    defaults();
    test_reset();
    test_basic();
    test_valid_gaps();
    test_stall();
    test_pe_done();
    test_reset_mid_load();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
